i2c_slave_regfile: RTL and testbench

I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_line_filter.sv | 52 +++++
 rtl/i2c_slave_regfile.sv | 223 ++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK bit levels and filter bounds,
// common to the slave register file and the master.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdAck,
    StIgnore
  } i2c_state_e;

  localparam logic AckBit  = 1'b0;
  localparam logic NackBit = 1'b1;

  localparam int unsigned FiltLenMax = 15;
  localparam int unsigned FiltCntW   = $clog2(FiltLenMax + 1);

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser, stability filter and edge detector for one I2C line.
// The filtered level only follows the input after FiltLen consecutive differing samples.
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int unsigned FiltLen = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic line_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0]          sync_q;
  logic [FiltCntW-1:0] cnt_q, cnt_d;
  logic                filt_q, filt_d;
  logic                prev_q;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == FiltCntW'(FiltLen - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Reset loads the idle-bus level so leaving reset never produces a spurious edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], line_i};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      prev_q <= filt_q;
    end
  end

  assign line_o = filt_q;
  assign rise_o = filt_q & ~prev_q;
  assign fall_o = ~filt_q & prev_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing NUM_REGS byte registers with an auto-incrementing pointer,
// plus a local combinational read port and a write-notification strobe.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h72,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned FILT_LEN   = 3,
  localparam int unsigned IdxW      = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            SCL,
  inout  wire             SDA,
  input  logic [IdxW-1:0] rd_sel,
  output logic [7:0]      rd_data,
  output logic            wr_stb,
  output logic [IdxW-1:0] wr_idx,
  output logic [7:0]      wr_val,
  output logic            busy
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_line_filter #(.FiltLen(FILT_LEN)) u_scl_filt (
    .clk_i  (clk),
    .rst_ni (rst),
    .line_i (SCL),
    .line_o (scl_f),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_filter #(.FiltLen(FILT_LEN)) u_sda_filt (
    .clk_i  (clk),
    .rst_ni (rst),
    .line_i (SDA),
    .line_o (sda_f),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2c_state_e      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            sda_oe_q, sda_oe_d;
  logic            busy_q, busy_d;
  logic            rw_q, rw_d;
  logic            mack_q, mack_d;
  logic            wr_stb_q, wr_stb_d;
  logic [IdxW-1:0] wr_idx_q, wr_idx_d;
  logic [7:0]      wr_val_q, wr_val_d;
  logic [7:0]      regs_q [NUM_REGS];
  logic            reg_we;
  logic [7:0]      rx_byte;
  logic [7:0]      cur_reg;
  logic            start_det, stop_det;

  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;
  assign rx_byte   = {shift_q[6:0], sda_f};
  assign cur_reg   = regs_q[ptr_q];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    rw_d     = rw_q;
    mack_d   = mack_q;
    wr_stb_d = 1'b0;
    wr_idx_d = wr_idx_q;
    wr_val_d = wr_val_q;
    reg_we   = 1'b0;

    if (stop_det) begin
      state_d  = StIdle;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = StAddr;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StIgnore: begin
        end
        StAddr, StPtr, StWdata: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            // Commit on the 8th rise so an interrupted byte never reaches the registers.
            if (state_q == StWdata && cnt_q == 4'd7) begin
              reg_we   = 1'b1;
              wr_stb_d = 1'b1;
              wr_idx_d = ptr_q;
              wr_val_d = rx_byte;
              ptr_d    = ptr_q + 1'b1;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            if (state_q == StAddr) begin
              if (shift_q[7:1] == SLAVE_ADDR) begin
                state_d  = StAddrAck;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = shift_q[0];
              end else begin
                state_d = StIgnore;
              end
            end else if (state_q == StPtr) begin
              state_d  = StPtrAck;
              ptr_d    = shift_q[IdxW-1:0];
              sda_oe_d = 1'b1;
            end else begin
              state_d  = StWdataAck;
              sda_oe_d = 1'b1;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (rw_q) begin
              state_d  = StRdata;
              shift_d  = cur_reg;
              ptr_d    = ptr_q + 1'b1;
              sda_oe_d = ~cur_reg[7];
            end else begin
              state_d  = StPtr;
              sda_oe_d = 1'b0;
            end
          end
        end
        StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            state_d  = StWdata;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
          end
        end
        StRdata: begin
          if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              state_d  = StRdAck;
              cnt_d    = '0;
              sda_oe_d = 1'b0;
            end else begin
              cnt_d    = cnt_q + 4'd1;
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            mack_d = sda_f;
          end else if (scl_fall) begin
            cnt_d = '0;
            if (mack_q == AckBit) begin
              state_d  = StRdata;
              shift_d  = cur_reg;
              ptr_d    = ptr_q + 1'b1;
              sda_oe_d = ~cur_reg[7];
            end else begin
              state_d  = StIgnore;
              sda_oe_d = 1'b0;
            end
          end
        end
        default: begin
          state_d  = StIdle;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shift_q  <= '0;
      ptr_q    <= '0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      rw_q     <= 1'b0;
      mack_q   <= NackBit;
      wr_stb_q <= 1'b0;
      wr_idx_q <= '0;
      wr_val_q <= '0;
      regs_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      ptr_q    <= ptr_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      rw_q     <= rw_d;
      mack_q   <= mack_d;
      wr_stb_q <= wr_stb_d;
      wr_idx_q <= wr_idx_d;
      wr_val_q <= wr_val_d;
      if (reg_we) begin
        regs_q[ptr_q] <= rx_byte;
      end
    end
  end

  assign SDA     = sda_oe_q ? 1'b0 : 1'bz;
  assign rd_data = regs_q[rd_sel];
  assign wr_stb  = wr_stb_q;
  assign wr_idx  = wr_idx_q;
  assign wr_val  = wr_val_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench: bit-banged I2C master against three slaves on one open-drain bus,
// with a register-array reference model per slave.
module tb_i2c_slave_regfile;

  localparam int unsigned NRegs = 8;
  localparam int unsigned QNs   = 250;  // quarter SCL period, clk period is 10

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  wire  sda_bus;

  pullup pu_sda (sda_bus);
  assign sda_bus = sda_m ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  logic [2:0] rd_sel   [3];
  logic [7:0] rd_data  [3];
  logic       wr_stb   [3];
  logic [2:0] wr_idx   [3];
  logic [7:0] wr_val   [3];
  logic       busy     [3];
  logic [6:0] addrs    [3];
  logic [7:0] mdl      [3][NRegs];
  int         stb_cnt  [3];
  logic [2:0] last_idx [3];
  logic [7:0] last_val [3];
  int         checks = 0;
  int         errors = 0;

  initial begin
    addrs[0] = 7'h72;
    addrs[1] = 7'h55;
    addrs[2] = 7'h01;
    for (int k = 0; k < 3; k++) begin
      rd_sel[k]  = '0;
      stb_cnt[k] = 0;
    end
  end

  i2c_slave_regfile #(.SLAVE_ADDR(7'h72)) u_s72 (
    .clk(clk), .rst(rst), .SCL(scl_m), .SDA(sda_bus), .rd_sel(rd_sel[0]), .rd_data(rd_data[0]),
    .wr_stb(wr_stb[0]), .wr_idx(wr_idx[0]), .wr_val(wr_val[0]), .busy(busy[0])
  );
  i2c_slave_regfile #(.SLAVE_ADDR(7'h55)) u_s55 (
    .clk(clk), .rst(rst), .SCL(scl_m), .SDA(sda_bus), .rd_sel(rd_sel[1]), .rd_data(rd_data[1]),
    .wr_stb(wr_stb[1]), .wr_idx(wr_idx[1]), .wr_val(wr_val[1]), .busy(busy[1])
  );
  i2c_slave_regfile #(.SLAVE_ADDR(7'h01)) u_s01 (
    .clk(clk), .rst(rst), .SCL(scl_m), .SDA(sda_bus), .rd_sel(rd_sel[2]), .rd_data(rd_data[2]),
    .wr_stb(wr_stb[2]), .wr_idx(wr_idx[2]), .wr_val(wr_val[2]), .busy(busy[2])
  );

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (wr_stb[k] === 1'b1) begin
        stb_cnt[k]  = stb_cnt[k] + 1;
        last_idx[k] = wr_idx[k];
        last_val[k] = wr_val[k];
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  // ---------------- bus master ----------------
  task automatic bus_start();
    @(negedge clk);
    if (!scl_m) begin
      #QNs sda_m = 1'b1;
      #QNs scl_m = 1'b1;
      #QNs;
    end
    sda_m = 1'b0;
    #QNs scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    #QNs sda_m = 1'b0;
    #QNs scl_m = 1'b1;
    #QNs sda_m = 1'b1;
    #QNs;
  endtask

  task automatic put_bit(input logic b);
    #QNs sda_m = b;
    #QNs scl_m = 1'b1;
    #(2 * QNs) scl_m = 1'b0;
  endtask

  task automatic get_bit(output logic b);
    #QNs sda_m = 1'b1;
    #QNs scl_m = 1'b1;
    #QNs b = sda_bus;
    #QNs scl_m = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(input logic mack, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(mack);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy[k] !== 1'b0 || wr_stb[k] !== 1'b0 || wr_idx[k] !== 3'd0 || wr_val[k] !== 8'h00) begin
        errors++;
        $display("FAIL reset_outs inst=%0d got busy=%b stb=%b idx=%h val=%h want 0 0 0 00",
                 k, busy[k], wr_stb[k], wr_idx[k], wr_val[k]);
      end
      for (int r = 0; r < NRegs; r++) begin
        mdl[k][r] = 8'h00;
        rd_sel[k] = 3'(r);
        @(negedge clk);
        checks++;
        if (rd_data[k] !== 8'h00) begin
          errors++;
          $display("FAIL reset_reg inst=%0d r=%0d got %h want 00", k, r, rd_data[k]);
        end
      end
    end
    checks++;
    if (sda_bus !== 1'b1) begin
      errors++;
      $display("FAIL reset_sda got %b want 1", sda_bus);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_single();
    logic ack;
    int   s [3];
    for (int k = 0; k < 3; k++) s[k] = stb_cnt[k];
    bus_start();
    put_byte({7'h72, 1'b0}, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL ws_addr_ack got %b want 0", ack); end
    checks++;
    if (busy[0] !== 1'b1 || busy[1] !== 1'b0 || busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL ws_busy got %b%b%b want 100", busy[0], busy[1], busy[2]);
    end
    put_byte(8'h02, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL ws_ptr_ack got %b want 0", ack); end
    put_byte(8'hA8, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL ws_data_ack got %b want 0", ack); end
    bus_stop();
    mdl[0][2] = 8'hA8;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (stb_cnt[k] - s[k] !== ((k == 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL ws_stb_cnt inst=%0d got %0d want %0d", k, stb_cnt[k] - s[k], (k == 0) ? 1 : 0);
      end
      checks++;
      if (busy[k] !== 1'b0) begin errors++; $display("FAIL ws_busy_end inst=%0d got 1 want 0", k); end
    end
    checks++;
    if (last_idx[0] !== 3'd2 || last_val[0] !== 8'hA8) begin
      errors++;
      $display("FAIL ws_wr got idx=%h val=%h want 2 a8", last_idx[0], last_val[0]);
    end
    rd_sel[0] = 3'd2;
    @(negedge clk);
    checks++;
    if (rd_data[0] !== 8'hA8) begin errors++; $display("FAIL ws_rd got %h want a8", rd_data[0]); end
  endtask

  task automatic test_no_ack();
    logic ack;
    int   s [3];
    for (int k = 0; k < 3; k++) s[k] = stb_cnt[k];
    bus_start();
    put_byte({7'h13, 1'b0}, ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL na_ack got %b want 1", ack); end
    checks++;
    if (busy[0] !== 1'b0 || busy[1] !== 1'b0 || busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL na_busy got %b%b%b want 000", busy[0], busy[1], busy[2]);
    end
    put_byte(8'h00, ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL na_ignore_ack got %b want 1", ack); end
    bus_stop();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (stb_cnt[k] !== s[k]) begin
        errors++;
        $display("FAIL na_stb inst=%0d got %0d want %0d", k, stb_cnt[k], s[k]);
      end
    end
  endtask

  task automatic test_wrap();
    logic ack;
    int   s0;
    s0 = stb_cnt[0];
    bus_start();
    put_byte({7'h72, 1'b0}, ack);
    put_byte(8'h07, ack);
    put_byte(8'h11, ack);
    put_byte(8'h22, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL wrap_ack got %b want 0", ack); end
    bus_stop();
    mdl[0][7] = 8'h11;
    mdl[0][0] = 8'h22;
    checks++;
    if (stb_cnt[0] - s0 !== 2 || last_idx[0] !== 3'd0) begin
      errors++;
      $display("FAIL wrap_stb got n=%0d idx=%h want 2 0", stb_cnt[0] - s0, last_idx[0]);
    end
    rd_sel[0] = 3'd7;
    @(negedge clk);
    checks++;
    if (rd_data[0] !== mdl[0][7]) begin
      errors++;
      $display("FAIL wrap_reg7 got %h want %h", rd_data[0], mdl[0][7]);
    end
    rd_sel[0] = 3'd0;
    @(negedge clk);
    checks++;
    if (rd_data[0] !== mdl[0][0]) begin
      errors++;
      $display("FAIL wrap_reg0 got %h want %h", rd_data[0], mdl[0][0]);
    end
  endtask

  task automatic test_read_restart();
    logic       ack;
    logic [7:0] v;
    logic [7:0] d [2];
    d[0] = 8'($urandom);
    d[1] = 8'($urandom);
    bus_start();
    put_byte({7'h55, 1'b0}, ack);
    put_byte(8'h00, ack);
    put_byte(d[0], ack);
    put_byte(d[1], ack);
    bus_stop();
    mdl[1][0] = d[0];
    mdl[1][1] = d[1];
    bus_start();
    put_byte({7'h55, 1'b0}, ack);
    put_byte(8'h00, ack);
    bus_start();
    put_byte({7'h55, 1'b1}, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL rr_addr_ack got %b want 0", ack); end
    for (int i = 0; i < 2; i++) begin
      get_byte((i == 1) ? 1'b1 : 1'b0, v);
      checks++;
      if (v !== mdl[1][i]) begin
        errors++;
        $display("FAIL rr_byte%0d got %h want %h", i, v, mdl[1][i]);
      end
    end
    checks++;
    if (busy[1] !== 1'b1) begin errors++; $display("FAIL rr_busy got %b want 1", busy[1]); end
    get_byte(1'b1, v);
    checks++;
    if (v !== 8'hFF) begin errors++; $display("FAIL rr_after_nack got %h want ff", v); end
    bus_stop();
    checks++;
    if (busy[1] !== 1'b0) begin errors++; $display("FAIL rr_busy_end got %b want 0", busy[1]); end
  endtask

  task automatic test_random();
    logic       ack;
    logic [7:0] v;
    logic [7:0] pb;
    logic [7:0] d [2];
    int         k, p, n, s0;
    for (int it = 0; it < 3; it++) begin
      k  = $urandom_range(2, 0);
      pb = 8'($urandom);
      p  = pb % NRegs;
      n  = $urandom_range(2, 1);
      for (int i = 0; i < 2; i++) d[i] = 8'($urandom);
      s0 = stb_cnt[k];
      bus_start();
      put_byte({addrs[k], 1'b0}, ack);
      checks++;
      if (ack !== 1'b0 || busy[k] !== 1'b1) begin
        errors++;
        $display("FAIL rnd_addr it=%0d got ack=%b busy=%b want 0 1", it, ack, busy[k]);
      end
      put_byte(pb, ack);
      for (int i = 0; i < n; i++) begin
        put_byte(d[i], ack);
        mdl[k][(p + i) % NRegs] = d[i];
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL rnd_data_ack it=%0d got %b want 0", it, ack); end
      end
      bus_stop();
      checks++;
      if (stb_cnt[k] - s0 !== n || last_idx[k] !== 3'((p + n - 1) % NRegs) || last_val[k] !== d[n-1]) begin
        errors++;
        $display("FAIL rnd_stb it=%0d got n=%0d idx=%h val=%h want %0d %h %h", it, stb_cnt[k] - s0,
                 last_idx[k], last_val[k], n, 3'((p + n - 1) % NRegs), d[n-1]);
      end
      bus_start();
      put_byte({addrs[k], 1'b0}, ack);
      put_byte(pb, ack);
      bus_start();
      put_byte({addrs[k], 1'b1}, ack);
      for (int i = 0; i < n; i++) begin
        get_byte((i == n - 1) ? 1'b1 : 1'b0, v);
        checks++;
        if (v !== mdl[k][(p + i) % NRegs]) begin
          errors++;
          $display("FAIL rnd_read it=%0d i=%0d got %h want %h", it, i, v, mdl[k][(p + i) % NRegs]);
        end
      end
      bus_stop();
      for (int r = 0; r < NRegs; r++) begin
        rd_sel[k] = 3'(r);
        @(negedge clk);
        checks++;
        if (rd_data[k] !== mdl[k][r]) begin
          errors++;
          $display("FAIL rnd_local it=%0d inst=%0d r=%0d got %h want %h", it, k, r, rd_data[k], mdl[k][r]);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic       ack;
    logic [7:0] d;
    int         s0;
    d  = 8'($urandom);
    s0 = stb_cnt[0];
    bus_start();
    put_byte({7'h72, 1'b0}, ack);
    put_byte(8'h03, ack);
    for (int i = 7; i >= 4; i--) put_bit(d[i]);
    bus_stop();
    checks++;
    if (stb_cnt[0] !== s0 || busy[0] !== 1'b0 || sda_bus !== 1'b1) begin
      errors++;
      $display("FAIL ab_stop got stb=%0d busy=%b sda=%b want %0d 0 1", stb_cnt[0], busy[0], sda_bus, s0);
    end
    for (int r = 0; r < NRegs; r++) begin
      rd_sel[0] = 3'(r);
      @(negedge clk);
      checks++;
      if (rd_data[0] !== mdl[0][r]) begin
        errors++;
        $display("FAIL ab_stop_reg r=%0d got %h want %h", r, rd_data[0], mdl[0][r]);
      end
    end
    bus_start();
    put_byte({7'h72, 1'b0}, ack);
    put_byte(8'h03, ack);
    for (int i = 7; i >= 4; i--) put_bit(d[i]);
    rst = 1'b0;
    #30 rst = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < NRegs; r++) mdl[k][r] = 8'h00;
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL ab_rst_busy got %b want 0", busy[0]); end
    for (int i = 3; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL ab_rst_ack got %b want 1", ack); end
    bus_stop();
    checks++;
    if (stb_cnt[0] !== s0 || busy[0] !== 1'b0 || sda_bus !== 1'b1) begin
      errors++;
      $display("FAIL ab_rst got stb=%0d busy=%b sda=%b want %0d 0 1", stb_cnt[0], busy[0], sda_bus, s0);
    end
    for (int r = 0; r < NRegs; r++) begin
      rd_sel[0] = 3'(r);
      @(negedge clk);
      checks++;
      if (rd_data[0] !== mdl[0][r]) begin
        errors++;
        $display("FAIL ab_rst_reg r=%0d got %h want %h", r, rd_data[0], mdl[0][r]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_no_ack();
    test_wrap();
    test_read_restart();
    test_random();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
